// File: rtl/rh_axi4_aw_beat_gen_if.sv
// AXI4 write-address channel plus per-beat address output, bundled as one port.
// Latency: none, wires only.
// Backpressure: AWREADY throttles AW; BT_READY stalls the beat stream.
// Signals: AW* = AXI4 AW channel (ID, address, length, size, burst type);
//          BT_* = beat stream (valid/ready, ID, address, index, last, error).
// Modports: slave = beat generator side, master = AW source / beat consumer side.
interface rh_axi4_aw_beat_gen_if #(
    parameter int IW = 4,
    parameter int AW = 32
);
    logic          AWVALID;
    logic          AWREADY;
    logic [IW-1:0] AWID;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;

    logic          BT_VALID;
    logic          BT_READY;
    logic [IW-1:0] BT_ID;
    logic [AW-1:0] BT_ADDR;
    logic [7:0]    BT_IDX;
    logic          BT_LAST;
    logic          BT_ERR;

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, BT_READY,
        output AWREADY, BT_VALID, BT_ID, BT_ADDR, BT_IDX, BT_LAST, BT_ERR
    );

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST, BT_READY,
        input  AWREADY, BT_VALID, BT_ID, BT_ADDR, BT_IDX, BT_LAST, BT_ERR
    );
endinterface

// File: rtl/rh_axi4_aw_beat_gen.sv
// Expands one accepted AXI4 AW burst into per-beat addresses (FIXED/INCR/WRAP).
// Latency: first beat one cycle after the AW handshake; 1 beat/cycle; one idle cycle between bursts.
// Backpressure: beat outputs hold while BT_VALID && !BT_READY; AWREADY is low for the whole burst.
// Ports: ACLK clock; ARESET synchronous active-high reset;
//        bus (slave modport) carries the AW channel in and the beat stream out.
module rh_axi4_aw_beat_gen #(
    parameter int IW = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    rh_axi4_aw_beat_gen_if.slave  bus
);
    localparam int MAXSZ = $clog2(DW / 8);
    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic          awready_q, awready_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    idx_q, idx_d;
    logic          last_q, last_d;
    logic          err_q, err_d;
    logic [7:0]    len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic [AW-1:0] start_q, start_d;   // AWADDR as given, reused by FIXED
    logic [AW-1:0] base_q, base_d;     // WRAP window base B
    logic [AW-1:0] tot_q, tot_d;       // WRAP window size T
    logic [AW-1:0] cur_q, cur_d;       // INCR: aligned address; WRAP: offset in window

    // Capture-time decode of the incoming AW request.
    logic [AW-1:0] cap_nb, cap_tot, cap_a0, cap_base, cap_end;
    logic          cap_err;

    assign cap_nb   = ONE << bus.AWSIZE;
    assign cap_tot  = (AW'(bus.AWLEN) + ONE) << bus.AWSIZE;
    assign cap_a0   = bus.AWADDR & ~(cap_nb - ONE);
    assign cap_base = bus.AWADDR & ~(cap_tot - ONE);
    assign cap_end  = cap_a0 + cap_tot - ONE;

    always_comb begin
        cap_err = 1'b0;
        if (bus.AWBURST == 2'd3)
            cap_err = 1'b1;
        if (int'(bus.AWSIZE) > MAXSZ)
            cap_err = 1'b1;
        if (bus.AWBURST == B_WRAP) begin
            if (!(bus.AWLEN == 8'd1 || bus.AWLEN == 8'd3 ||
                  bus.AWLEN == 8'd7 || bus.AWLEN == 8'd15))
                cap_err = 1'b1;
            if ((bus.AWADDR & (cap_nb - ONE)) != '0)
                cap_err = 1'b1;
        end
        if (bus.AWBURST == B_INCR && cap_a0[AW-1:12] != cap_end[AW-1:12])
            cap_err = 1'b1;
    end

    // Next-beat address, computed incrementally. For WRAP the offset
    // A0-B is always below T (it is A0 masked by T-1), and one beat step
    // nb never exceeds T, so a single conditional subtract is an exact
    // modulo-T, including for the non-power-of-two T of illegal lengths.
    logic [AW-1:0] nb_q, step_sum, cur_next, beat_addr;

    assign nb_q     = ONE << size_q;
    assign step_sum = cur_q + nb_q;

    always_comb begin
        cur_next = step_sum;
        if (burst_q == B_WRAP && step_sum >= tot_q)
            cur_next = step_sum - tot_q;
        case (burst_q)
            B_INCR:  beat_addr = cur_next;
            B_WRAP:  beat_addr = base_q + cur_next;
            default: beat_addr = start_q;   // FIXED and reserved
        endcase
    end

    always_comb begin
        state_d   = state_q;
        awready_d = awready_q;
        valid_d   = valid_q;
        id_d      = id_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        last_d    = last_q;
        err_d     = err_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        start_d   = start_q;
        base_d    = base_q;
        tot_d     = tot_q;
        cur_d     = cur_q;
        case (state_q)
            S_IDLE: begin
                awready_d = 1'b1;
                valid_d   = 1'b0;
                if (bus.AWVALID && awready_q) begin
                    state_d   = S_BURST;
                    awready_d = 1'b0;
                    valid_d   = 1'b1;
                    id_d      = bus.AWID;
                    addr_d    = bus.AWADDR;
                    idx_d     = 8'd0;
                    last_d    = (bus.AWLEN == 8'd0);
                    err_d     = cap_err;
                    len_d     = bus.AWLEN;
                    size_d    = bus.AWSIZE;
                    burst_d   = bus.AWBURST;
                    start_d   = bus.AWADDR;
                    base_d    = cap_base;
                    tot_d     = cap_tot;
                    cur_d     = (bus.AWBURST == B_WRAP) ? (cap_a0 - cap_base) : cap_a0;
                end
            end
            S_BURST: begin
                if (valid_q && bus.BT_READY) begin
                    if (last_q) begin
                        state_d   = S_IDLE;
                        valid_d   = 1'b0;
                        awready_d = 1'b1;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        last_d = ((idx_q + 8'd1) == len_q);
                        cur_d  = cur_next;
                        addr_d = beat_addr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= B_FIXED;
            start_q   <= '0;
            base_q    <= '0;
            tot_q     <= '0;
            cur_q     <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            err_q     <= err_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            start_q   <= start_d;
            base_q    <= base_d;
            tot_q     <= tot_d;
            cur_q     <= cur_d;
        end
    end

    assign bus.AWREADY  = awready_q;
    assign bus.BT_VALID = valid_q;
    assign bus.BT_ID    = id_q;
    assign bus.BT_ADDR  = addr_q;
    assign bus.BT_IDX   = idx_q;
    assign bus.BT_LAST  = last_q;
    assign bus.BT_ERR   = err_q;
endmodule
